// File: rtl/mips_decoder.sv
// MIPS-subset instruction decoder: zero-latency combinational controls, no backpressure.
// Optional sticky illegal-instruction flag built when DECODE_STICKY_ILLEGAL_EN is defined.
module mips_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        RegWrite,
    output logic [4:0]  A3,
    output logic [1:0]  RegDst,
    output logic [3:0]  EXTOp,
    output logic [2:0]  NPCOp,
    output logic [2:0]  ALUOp,
    output logic        ALUSrc,
    output logic        MemWrite,
    output logic [1:0]  WDSel,
    output logic        illegal,
    output logic        illegal_seen
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_NOP   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [3:0] EXT_ZERO = 4'd0;
    localparam logic [3:0] EXT_SIGN = 4'd1;
    localparam logic [3:0] EXT_HIGH = 4'd2;
    localparam logic [3:0] EXT_NONE = 4'd15;

    localparam logic [2:0] NPC_SEQ  = 3'd0;
    localparam logic [2:0] NPC_B    = 3'd1;
    localparam logic [2:0] NPC_J    = 3'd2;
    localparam logic [2:0] NPC_R    = 3'd3;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_PASS = 3'd3;

    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_RA   = 2'd2;

    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_DM    = 2'd1;
    localparam logic [1:0] WD_PC8   = 2'd2;

    logic [5:0] op;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;

    assign op    = instr[31:26];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign funct = instr[5:0];

    // rs, shamt and the immediate are consumed by other pipeline blocks, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = &{1'b0, instr[25:21], instr[10:6]};

    always_comb begin
        RegWrite = 1'b0;
        RegDst   = DST_RT;
        EXTOp    = EXT_ZERO;
        NPCOp    = NPC_SEQ;
        ALUOp    = ALU_ADD;
        ALUSrc   = 1'b0;
        MemWrite = 1'b0;
        WDSel    = WD_ALU;
        illegal  = 1'b0;

        unique case (op)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADDU: begin
                        RegWrite = 1'b1;
                        RegDst   = DST_RD;
                        EXTOp    = EXT_NONE;
                        ALUOp    = ALU_ADD;
                    end
                    FN_SUBU: begin
                        RegWrite = 1'b1;
                        RegDst   = DST_RD;
                        EXTOp    = EXT_NONE;
                        ALUOp    = ALU_SUB;
                    end
                    FN_JR: begin
                        NPCOp = NPC_R;
                    end
                    FN_NOP: begin
                        EXTOp = EXT_NONE;
                    end
                    default: begin
                        illegal = 1'b1;
                        EXTOp   = EXT_NONE;
                    end
                endcase
            end
            OP_ORI: begin
                RegWrite = 1'b1;
                RegDst   = DST_RT;
                EXTOp    = EXT_ZERO;
                ALUSrc   = 1'b1;
                ALUOp    = ALU_OR;
            end
            OP_LUI: begin
                RegWrite = 1'b1;
                RegDst   = DST_RT;
                EXTOp    = EXT_HIGH;
                ALUSrc   = 1'b1;
                ALUOp    = ALU_PASS;
            end
            OP_LW: begin
                RegWrite = 1'b1;
                RegDst   = DST_RT;
                EXTOp    = EXT_SIGN;
                ALUSrc   = 1'b1;
                ALUOp    = ALU_ADD;
                WDSel    = WD_DM;
            end
            OP_SW: begin
                MemWrite = 1'b1;
                EXTOp    = EXT_SIGN;
                ALUSrc   = 1'b1;
                ALUOp    = ALU_ADD;
            end
            OP_BEQ: begin
                NPCOp = NPC_B;
                EXTOp = EXT_SIGN;
                ALUOp = ALU_SUB;
            end
            OP_J: begin
                NPCOp = NPC_J;
            end
            OP_JAL: begin
                NPCOp    = NPC_J;
                RegWrite = 1'b1;
                RegDst   = DST_RA;
                WDSel    = WD_PC8;
            end
            default: begin
                illegal = 1'b1;
                EXTOp   = EXT_NONE;
            end
        endcase
    end

    // Non-writing instructions report A3=0 so hazard logic never matches them.
    always_comb begin
        A3 = 5'd0;
        if (RegWrite) begin
            unique case (RegDst)
                DST_RD:  A3 = rd;
                DST_RA:  A3 = 5'd31;
                default: A3 = rt;
            endcase
        end
    end

`ifdef DECODE_STICKY_ILLEGAL_EN
    logic illegal_seen_q;
    logic illegal_seen_d;

    always_comb begin
        illegal_seen_d = illegal_seen_q | illegal;
        if (reset) begin
            illegal_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        illegal_seen_q <= illegal_seen_d;
    end

    assign illegal_seen = illegal_seen_q;
`else
    logic unused_clk_reset;
    assign unused_clk_reset = &{1'b0, clk, reset};
    assign illegal_seen     = 1'b0;
`endif

endmodule

// File: tb/tb_mips_decoder.sv
// Table-driven bench for mips_decoder plus a short sequence for the sticky illegal flag.
module tb_mips_decoder;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        RegWrite;
    logic [4:0]  A3;
    logic [1:0]  RegDst;
    logic [3:0]  EXTOp;
    logic [2:0]  NPCOp;
    logic [2:0]  ALUOp;
    logic        ALUSrc;
    logic        MemWrite;
    logic [1:0]  WDSel;
    logic        illegal;
    logic        illegal_seen;

    int tests_run;
    int tests_failed;

    mips_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .RegWrite     (RegWrite),
        .A3           (A3),
        .RegDst       (RegDst),
        .EXTOp        (EXTOp),
        .NPCOp        (NPCOp),
        .ALUOp        (ALUOp),
        .ALUSrc       (ALUSrc),
        .MemWrite     (MemWrite),
        .WDSel        (WDSel),
        .illegal      (illegal),
        .illegal_seen (illegal_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Layout {RegWrite, A3, RegDst, EXTOp, NPCOp, ALUOp, ALUSrc, MemWrite, WDSel, illegal}
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [22:0] exp;
        logic [22:0] mask;
    } vec_t;

    function automatic logic [22:0] mk(input logic rw, input logic [4:0] a3,
                                       input logic [1:0] dst, input logic [3:0] ext,
                                       input logic [2:0] npc, input logic [2:0] alu,
                                       input logic src, input logic mw,
                                       input logic [1:0] wd, input logic ill);
        return {rw, a3, dst, ext, npc, alu, src, mw, wd, ill};
    endfunction

    localparam logic [22:0] ALL    = 23'h7FFFFF;
    localparam logic [22:0] NO_EXT = ~(23'hF << 11);

    vec_t vecs[$];

    task automatic check1(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        logic [22:0] act;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        instr        = 32'h0;

        //                      name    instr          rw a3  dst ext  npc alu src mw wd ill
        vecs.push_back('{"addu",  32'h00221821, mk(1, 3,  1, 15, 0, 0, 0, 0, 0, 0), ALL});
        vecs.push_back('{"subu",  32'h00221823, mk(1, 3,  1, 15, 0, 1, 0, 0, 0, 0), ALL});
        vecs.push_back('{"ori",   32'h34011234, mk(1, 1,  0, 0,  0, 2, 1, 0, 0, 0), ALL});
        vecs.push_back('{"lui",   32'h3C01ABCD, mk(1, 1,  0, 2,  0, 3, 1, 0, 0, 0), ALL});
        vecs.push_back('{"lw",    32'h8C220004, mk(1, 2,  0, 1,  0, 0, 1, 0, 1, 0), ALL});
        vecs.push_back('{"sw",    32'hAC220004, mk(0, 0,  0, 1,  0, 0, 1, 1, 0, 0), ALL});
        vecs.push_back('{"beq",   32'h10220003, mk(0, 0,  0, 1,  1, 1, 0, 0, 0, 0), ALL});
        vecs.push_back('{"j",     32'h08000C00, mk(0, 0,  0, 0,  2, 0, 0, 0, 0, 0), NO_EXT});
        vecs.push_back('{"jal",   32'h0C000C00, mk(1, 31, 2, 0,  2, 0, 0, 0, 2, 0), NO_EXT});
        vecs.push_back('{"jr",    32'h03E00008, mk(0, 0,  0, 0,  3, 0, 0, 0, 0, 0), NO_EXT});
        vecs.push_back('{"nop",   32'h00000000, mk(0, 0,  0, 15, 0, 0, 0, 0, 0, 0), ALL});
        vecs.push_back('{"sll0",  32'h00221800, mk(0, 0,  0, 15, 0, 0, 0, 0, 0, 0), ALL});
        vecs.push_back('{"badop", 32'hFC000000, mk(0, 0,  0, 15, 0, 0, 0, 0, 0, 1), ALL});
        vecs.push_back('{"op07",  32'h1C221821, mk(0, 0,  0, 15, 0, 0, 0, 0, 0, 1), ALL});
        vecs.push_back('{"add20", 32'h00221820, mk(0, 0,  0, 15, 0, 0, 0, 0, 0, 1), ALL});
        vecs.push_back('{"lui31", 32'h3C1FFFFF, mk(1, 31, 0, 2,  0, 3, 1, 0, 0, 0), ALL});

        // Two reset cycles, then the sticky flag must read clear.
        @(posedge clk); #1;
        @(posedge clk); #1;
        check1("seen_after_reset", illegal_seen, 1'b0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            v     = vecs[i];
            instr = v.instr;
            #1;
            act = {RegWrite, A3, RegDst, EXTOp, NPCOp, ALUOp, ALUSrc, MemWrite, WDSel, illegal};
            tests_run++;
            if ((act & v.mask) !== (v.exp & v.mask)) begin
                tests_failed++;
                $display("FAIL %s: got %06h, expected %06h (mask %06h)",
                         v.name, act, v.exp, v.mask);
            end
        end

`ifdef DECODE_STICKY_ILLEGAL_EN
        // Fresh reset so the table's illegal vectors (never clocked in) leave no trace.
        reset = 1'b1;
        instr = 32'h00221821;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check1("seen_legal_only", illegal_seen, 1'b0);
        instr = 32'hFC000000;
        @(posedge clk); #1;
        instr = 32'h34011234;
        check1("seen_set", illegal_seen, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check1("seen_held", illegal_seen, 1'b1);
        end
        reset = 1'b1;
        instr = 32'hFC000000;
        #1;
        check1("illegal_during_reset", illegal, 1'b1);
        @(posedge clk); #1;
        check1("reset_wins", illegal_seen, 1'b0);
        reset = 1'b0;
        instr = 32'h00000000;
        @(posedge clk); #1;
        check1("seen_after_reset_release", illegal_seen, 1'b0);
`else
        instr = 32'hFC000000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check1("seen_tied_low", illegal_seen, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
